// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, order-FSM encodings and defaults shared by the 7-segment scan decoder.
package seg7_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 4;

    // Lit-segment sets {g,f,e,d,c,b,a} for hex 0..F; index = hex value.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        EXP0 = 2'd0,
        EXP1 = 2'd1,
        EXP2 = 2'd2,
        EXP3 = 2'd3
    } ord_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps a lit-segment set to its hex value, flagging sets that match no digit.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] lit_i,
    output logic       legal_o,
    output logic [3:0] hex_o
);

    always_comb begin
        legal_o = 1'b0;
        hex_o   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (lit_i == SEG_PAT[i]) begin
                legal_o = 1'b1;
                hex_o   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a multiplexed active-low 7-segment display scan,
// capturing each digit once its strobes have been stable long enough and checking scan order.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic        i_w_clk,
    input  logic        i_w_reset,
    input  logic [3:0]  i_w_AN,
    input  logic [6:0]  i_w_SEG,
    input  logic        i_w_DP,
    output logic [15:0] o_r_digit,
    output logic [3:0]  o_r_valid,
    output logic [3:0]  o_r_dp,
    output logic        o_r_frame,
    output logic        o_r_err_anode,
    output logic        o_r_err_order,
    output logic        o_r_err_seg
);

    localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

    logic [11:0] samp_q, samp_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic [15:0] digit_q, digit_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  dp_q, dp_d;
    logic        frame_q, frame_d;
    logic        err_anode_q, err_anode_d;
    logic        err_order_q, err_order_d;
    logic        err_seg_q, err_seg_d;
    ord_state_e  state_q, state_d;

    logic [3:0]  sel;
    logic [6:0]  lit;
    logic [1:0]  k;
    logic        legal;
    logic [3:0]  hex;

    assign sel = ~samp_q[11:8];
    assign lit = ~samp_q[7:1];

    seg7_pattern_decode u_decode (
        .lit_i   (lit),
        .legal_o (legal),
        .hex_o   (hex)
    );

    always_comb begin
        samp_d      = {i_w_AN, i_w_SEG, i_w_DP};
        cnt_d       = (samp_d != samp_q) ? 16'd1 : (cnt_q == STABLE) ? STABLE : cnt_q + 16'd1;
        // Fire only on the transition into saturation so a dwell captures once.
        hit_d       = (cnt_d == STABLE) && (cnt_q != STABLE);
        k           = 2'd0;
        digit_d     = digit_q;
        valid_d     = valid_q;
        dp_d        = dp_q;
        state_d     = state_q;
        frame_d     = 1'b0;
        err_anode_d = 1'b0;
        err_order_d = 1'b0;
        err_seg_d   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) k = 2'(i);
        end
        if (hit_q && sel != 4'd0) begin
            if ($countones(sel) > 1) begin
                err_anode_d = 1'b1;
            end else begin
                dp_d[k] = ~samp_q[0];
                if (legal) begin
                    digit_d[{k, 2'b00} +: 4] = hex;
                    valid_d[k]               = 1'b1;
                end else begin
                    valid_d[k] = 1'b0;
                    err_seg_d  = 1'b1;
                end
                if (k == state_q) begin
                    state_d = (k == 2'd3) ? EXP0 : ord_state_e'(k + 2'd1);
                    frame_d = (k == 2'd3);
                end else begin
                    err_order_d = 1'b1;
                    state_d     = (k == 2'd0) ? EXP1 : EXP0;
                end
            end
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            samp_q      <= '1;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            digit_q     <= '0;
            valid_q     <= '0;
            dp_q        <= '0;
            state_q     <= EXP0;
            frame_q     <= 1'b0;
            err_anode_q <= 1'b0;
            err_order_q <= 1'b0;
            err_seg_q   <= 1'b0;
        end else begin
            samp_q      <= samp_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            digit_q     <= digit_d;
            valid_q     <= valid_d;
            dp_q        <= dp_d;
            state_q     <= state_d;
            frame_q     <= frame_d;
            err_anode_q <= err_anode_d;
            err_order_q <= err_order_d;
            err_seg_q   <= err_seg_d;
        end
    end

    assign o_r_digit     = digit_q;
    assign o_r_valid     = valid_q;
    assign o_r_dp        = dp_q;
    assign o_r_frame     = frame_q;
    assign o_r_err_anode = err_anode_q;
    assign o_r_err_order = err_order_q;
    assign o_r_err_seg   = err_seg_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: randomized and directed scans scored against a digit-level reference model.
module tb_seg7_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an  = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic        dp  = 1'b1;
    logic [15:0] digit;
    logic [3:0]  valid, dpo;
    logic        frame, err_anode, err_order, err_seg;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .i_w_clk       (clk),
        .i_w_reset     (rst),
        .i_w_AN        (an),
        .i_w_SEG       (seg),
        .i_w_DP        (dp),
        .o_r_digit     (digit),
        .o_r_valid     (valid),
        .o_r_dp        (dpo),
        .o_r_frame     (frame),
        .o_r_err_anode (err_anode),
        .o_r_err_order (err_order),
        .o_r_err_seg   (err_seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          when;
        logic [15:0] digit;
        logic [3:0]  valid;
        logic [3:0]  dp;
        logic        frame, ea, eo, es;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    string seg_tab[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    int          m_dig[4];
    logic [3:0]  m_valid, m_dp;
    int          m_exp;
    logic [11:0] cur_pat;
    int          run_len;

    function automatic logic [6:0] lit_of(string s);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            if (failures < 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
            failures++;
        end
    endfunction

    function automatic exp_t snapshot(int when);
        exp_t e;
        e.when  = when;
        e.digit = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
        e.valid = m_valid;
        e.dp    = m_dp;
        e.frame = 1'b0;
        e.ea    = 1'b0;
        e.eo    = 1'b0;
        e.es    = 1'b0;
        return e;
    endfunction

    // Reference: what one completed dwell of {a_n, s_n, d_n} does to the displayed state.
    function automatic void model_capture(logic [3:0] a_n, logic [6:0] s_n, logic d_n, int when);
        exp_t e;
        logic [3:0] sel;
        int k, hex;
        sel = ~a_n;
        if (sel == 4'd0) return;
        if ($countones(sel) > 1) begin
            e = snapshot(when);
            e.ea = 1'b1;
            q.push_back(e);
            return;
        end
        k = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) k = i;
        hex = -1;
        for (int h = 0; h < 16; h++) if (lit_of(seg_tab[h]) == ~s_n) hex = h;
        m_dp[k] = ~d_n;
        if (hex >= 0) begin
            m_dig[k]   = hex;
            m_valid[k] = 1'b1;
        end else begin
            m_valid[k] = 1'b0;
        end
        e = snapshot(when);
        e.es = (hex < 0);
        if (k == m_exp) begin
            e.frame = (k == 3);
            m_exp   = (k + 1) % 4;
        end else begin
            e.eo  = 1'b1;
            m_exp = (k == 0) ? 1 : 0;
        end
        q.push_back(e);
    endfunction

    task automatic drive(input logic [3:0] a_n, input logic [6:0] s_n, input logic d_n, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            an  = a_n;
            seg = s_n;
            dp  = d_n;
            if ({a_n, s_n, d_n} != cur_pat) begin
                cur_pat = {a_n, s_n, d_n};
                run_len = 1;
            end else begin
                run_len++;
            end
            if (run_len == S) model_capture(a_n, s_n, d_n, cyc + 2);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_valid = '0;
        m_dp    = '0;
        m_exp   = 0;
        q.push_back(snapshot(cyc + 1));
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        cur_pat = {an, seg, dp};
        run_len = 1;
    endtask

    initial begin : monitor
        exp_t cur;
        bit started;
        started = 1'b0;
        cur = snapshot(0);
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0 && q[0].when == cyc) begin
                cur = q.pop_front();
                started = 1'b1;
                chk("digit", 32'(digit), 32'(cur.digit));
                chk("valid", 32'(valid), 32'(cur.valid));
                chk("dp", 32'(dpo), 32'(cur.dp));
                chk("frame", 32'(frame), 32'(cur.frame));
                chk("err_anode", 32'(err_anode), 32'(cur.ea));
                chk("err_order", 32'(err_order), 32'(cur.eo));
                chk("err_seg", 32'(err_seg), 32'(cur.es));
            end else if (started) begin
                chk("idle_outputs", {digit, valid, dpo, 8'h00}, {cur.digit, cur.valid, cur.dp, 8'h00});
                chk("idle_pulses", 32'({frame, err_anode, err_order, err_seg}), 32'd0);
            end
        end
    end

    initial begin : stimulus
        logic [6:0] segs[4];
        logic [3:0] a_n;
        logic [6:0] s_n;
        int k;
        segs[0] = 7'b1000000;
        segs[1] = 7'b1111001;
        segs[2] = 7'b0100100;
        segs[3] = 7'b0110000;
        cur_pat = '1;
        run_len = 0;
        do_reset(3);
        drive(4'b1110, segs[0], 1'b1, S);
        drive(4'b1111, 7'h7F, 1'b1, 4);
        for (int d = 0; d < 4; d++) drive(~(4'b0001 << d), segs[d], 1'b1, 1000);
        drive(4'b1100, segs[0], 1'b1, 10);
        drive(4'b1110, segs[0], 1'b0, 6);
        drive(4'b1011, segs[2], 1'b1, 6);
        for (int d = 0; d < 4; d++) drive(~(4'b0001 << d), segs[d], 1'b1, 6);
        drive(4'b1101, 7'b1111110, 1'b1, 6);
        repeat (5) begin
            drive(4'b1110, segs[1], 1'b1, 3);
            drive(4'b1110, segs[2], 1'b1, 3);
        end
        drive(4'b0111, segs[3], 1'b1, 2);
        do_reset(2);
        drive(4'b0111, segs[3], 1'b1, 4);
        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 19))
                0, 1, 2:  a_n = 4'hF;
                3, 4, 5:  a_n = 4'($urandom_range(0, 15));
                default: begin
                    k = ($urandom_range(0, 1) == 1) ? m_exp : int'($urandom_range(0, 3));
                    a_n = ~(4'b0001 << k);
                end
            endcase
            s_n = ($urandom_range(0, 9) < 7) ? ~lit_of(seg_tab[$urandom_range(0, 15)]) : 7'($urandom);
            drive(a_n, s_n, 1'($urandom), int'($urandom_range(1, 7)));
            if ($urandom_range(0, 49) == 0) do_reset(int'($urandom_range(1, 3)));
        end
        drive(4'hF, 7'h7F, 1'b1, 10);
        chk("drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
